inv_sub_bytes_seq: RTL and testbench

Iterative AES inverse SubBytes engine for the decryption datapath. It accepts one 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through inverse S-box lookups. It returns the 128-bit result over a second valid/ready handshake. It sits between AddRoundKey/InvShiftRows and the round controller, and is the decrypt-side counterpart of the forward S-box.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/inv_sub_bytes_seq_if.sv | 21 ++
 rtl/inv_s_box.sv | 29 ++
 rtl/inv_sub_bytes_seq.sv | 103 ++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath definitions: block geometry, engine FSM states
// and byte extraction using the byte-0-at-MSB convention.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_BYTE_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   // Byte 0 occupies bits [127:120], so byte i starts at bit (15-i)*8 = {~i,3'b000}.
   function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [AES_BLOCK_W-1:0] s,
                                                      input logic [3:0] idx);
      return s[{~idx, 3'b000} +: AES_BYTE_W];
   endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Input and output valid/ready channels of the iterative inverse SubBytes engine.
interface inv_sub_bytes_seq_if;

   logic                            in_valid;
   logic                            in_ready;
   logic [aes_pkg::AES_BLOCK_W-1:0] in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [aes_pkg::AES_BLOCK_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/inv_s_box.sv
// Combinational AES inverse S-box, full 256-entry table.
module inv_s_box (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // Entry 0 sits in the most significant byte, one table row per line.
   localparam logic [2047:0] TABLE = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign out_byte = TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES inverse SubBytes: one 128-bit state in, BYTES_PER_CYCLE bytes
// substituted per clock, result held on a valid/ready output until taken.
module inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              busy,
   inv_sub_bytes_seq_if.slave bus
);

   localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
          BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
         $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [AES_BLOCK_W-1:0]  data_q;
   logic [AES_BLOCK_W-1:0]  data_sub;
   logic                    out_valid_q;
   logic [3:0]              base;
   logic [AES_BYTE_W-1:0]   sbox_in  [BYTES_PER_CYCLE];
   logic [AES_BYTE_W-1:0]   sbox_out [BYTES_PER_CYCLE];

   assign base = 4'(cnt * BYTES_PER_CYCLE);

   // One S-box per lane; the chunk counter steers which bytes the lanes see.
   generate
      for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
         assign sbox_in[g] = get_byte(data_q, base + 4'(g));
         inv_s_box u_inv_s_box (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
         );
      end
   endgenerate

   always_comb begin
      data_sub = data_q;
      for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
         data_sub[{~(base + 4'(g)), 3'b000} +: AES_BYTE_W] = sbox_out[g];
      end
   end

   // Clear aborts from any state but leaves the data register untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
      end else if (clear) begin
         state       <= IDLE;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q <= bus.in_data;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               data_q <= data_sub;
               if (cnt == CNT_W'(NCHUNK - 1)) begin
                  cnt         <= '0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: directed cases, randomized traffic
// against a block-level model, and a BYTES_PER_CYCLE latency sweep.
module tb_inv_sub_bytes_seq;
   import aes_pkg::*;

   localparam int BPC    = 4;
   localparam int NCHUNK = 16 / BPC;
   localparam logic [127:0] VEC3 = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] RES3 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam int SW_BPC [4] = '{1, 2, 8, 16};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inv_sub_bytes_seq_if bif ();

   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .busy  (busy),
      .bus   (bif.slave)
   );

   // Sweep instances share one stimulus and always accept their result.
   logic         sw_valid = 1'b0;
   logic [127:0] sw_data  = '0;
   logic         sw_ov [4];
   logic [127:0] sw_od [4];

   generate
      for (genvar g = 0; g < 4; g++) begin : g_sweep
         inv_sub_bytes_seq_if swif ();
         logic sw_busy;
         assign swif.in_valid  = sw_valid;
         assign swif.in_data   = sw_data;
         assign swif.out_ready = 1'b1;
         assign sw_ov[g]       = swif.out_valid;
         assign sw_od[g]       = swif.out_data;
         inv_sub_bytes_seq #(.BYTES_PER_CYCLE(SW_BPC[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (1'b0),
            .busy  (sw_busy),
            .bus   (swif.slave)
         );
      end
   endgenerate

   // Reference inverse S-box derived from GF(2^8) inversion plus the affine map.
   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic buildTables();
      logic [7:0] b;
      for (int a = 0; a < 256; a++) begin
         b = 8'h00;
         for (int c = 1; c < 256; c++) begin
            if (gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
         end
         fwd_tab[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);
   endtask

   function automatic logic [127:0] partial(input logic [127:0] d, input int nbytes);
      logic [127:0] r;
      r = d;
      for (int i = 0; i < 16; i++) begin
         if (i < nbytes) r[127 - 8*i -: 8] = inv_tab[d[127 - 8*i -: 8]];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Block-level model: one block outstanding, aged in edges since acceptance.
   logic         m_pending;
   int           m_age;
   logic [127:0] m_in;
   logic [127:0] m_hold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending <= 1'b0;
         m_age     <= 0;
         m_hold    <= '0;
      end else if (clear) begin
         if (m_pending) m_hold <= partial(m_in, m_age * BPC);
         m_pending <= 1'b0;
      end else if (!m_pending) begin
         if (bif.in_valid) begin
            m_pending <= 1'b1;
            m_age     <= 0;
            m_in      <= bif.in_data;
         end
      end else if (m_age < NCHUNK) begin
         m_age <= m_age + 1;
      end else if (bif.out_ready) begin
         m_pending <= 1'b0;
         m_hold    <= partial(m_in, 16);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("cyc_in_ready", bif.in_ready, !m_pending);
         checkOutput("cyc_busy", busy, m_pending);
         checkOutput("cyc_out_valid", bif.out_valid, m_pending && (m_age == NCHUNK));
         checkOutput("cyc_out_data", bif.out_data,
                     m_pending ? partial(m_in, m_age * BPC) : m_hold);
      end
   end

   task automatic waitCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [127:0] d, input logic r, input logic c);
      bif.in_valid  = v;
      bif.in_data   = d;
      bif.out_ready = r;
      clear         = c;
   endtask

   task automatic waitReady();
      for (int k = 0; k < 64 && !bif.in_ready; k++) waitCycle();
   endtask

   task automatic waitValid(output int lat);
      lat = -1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (bif.out_valid) begin
            lat = k;
            break;
         end
      end
      #1;
   endtask

   task automatic runBlock(input logic [127:0] d, output logic [127:0] got, output int lat);
      waitReady();
      applyStimulus(1'b1, d, bif.out_ready, 1'b0);
      waitCycle();
      bif.in_valid = 1'b0;
      waitValid(lat);
      got = bif.out_data;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_out_valid"}, bif.out_valid, 1'b0);
      checkOutput({tag, "_out_data"}, bif.out_data, 128'h0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_in_ready"}, bif.in_ready, 1'b1);
   endtask

   task automatic finishRun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      finishRun();
   end

   initial begin
      logic [127:0] got;
      int           lat;
      int           sw_lat [4];
      logic [127:0] sw_got [4];

      buildTables();
      checkOutput("model_fwd_00", fwd_tab[8'h00], 8'h63);
      checkOutput("model_inv_52", inv_tab[8'h52], 8'h48);
      checkOutput("model_inv_16", inv_tab[8'h16], 8'hff);
      checkOutput("model_inv_ff", inv_tab[8'hff], 8'h7d);
      checkOutput("model_inv_7c", inv_tab[8'h7c], 8'h01);
      checkOutput("model_vec3", partial(VEC3, 16), RES3);

      // Reset held for three cycles, outputs checked during and after it.
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      rst_n = 1'b0;
      repeat (3) waitCycle();
      checkResetOutputs("reset_hold");
      rst_n = 1'b1;
      waitCycle();
      checkResetOutputs("reset_release");

      runBlock({16{8'h63}}, got, lat);
      checkOutput("all63_latency", lat, NCHUNK);
      checkOutput("all63_data", got, 128'h0);
      runBlock({16{8'h00}}, got, lat);
      checkOutput("all00_data", got, {16{8'h52}});

      runBlock(VEC3, got, lat);
      checkOutput("vec3_latency", lat, NCHUNK);
      checkOutput("vec3_data", got, RES3);
      runBlock(128'h5216ff7c_00000000_63636363_637c777b, got, lat);
      checkOutput("bytes_data", got, 128'h48ff7d01_52525252_00000000_00010203);

      // Output backpressure with a competing input offered the whole time.
      waitReady();
      applyStimulus(1'b1, VEC3, 1'b0, 1'b0);
      waitCycle();
      bif.in_valid = 1'b0;
      waitValid(lat);
      checkOutput("bp_latency", lat, NCHUNK);
      applyStimulus(1'b1, {16{8'h63}}, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         waitCycle();
         checkOutput("bp_hold_data", bif.out_data, RES3);
         checkOutput("bp_hold_valid", bif.out_valid, 1'b1);
         checkOutput("bp_hold_in_ready", bif.in_ready, 1'b0);
      end
      bif.out_ready = 1'b1;
      waitCycle();
      checkOutput("bp_release_in_ready", bif.in_ready, 1'b1);
      waitCycle();
      bif.in_valid = 1'b0;
      waitValid(lat);
      checkOutput("bp_next_latency", lat, NCHUNK);
      checkOutput("bp_next_data", bif.out_data, 128'h0);

      // Clear on the second BUSY cycle.
      waitReady();
      applyStimulus(1'b1, VEC3, 1'b1, 1'b0);
      waitCycle();
      bif.in_valid = 1'b0;
      waitCycle();
      clear = 1'b1;
      waitCycle();
      clear = 1'b0;
      checkOutput("abort_in_ready", bif.in_ready, 1'b1);
      checkOutput("abort_busy", busy, 1'b0);
      for (int k = 0; k < 8; k++) begin
         checkOutput("abort_no_valid", bif.out_valid, 1'b0);
         waitCycle();
      end
      runBlock(VEC3, got, lat);
      checkOutput("abort_after_data", got, RES3);

      // Asynchronous reset pulse mid-BUSY, checked before any clock edge.
      waitReady();
      applyStimulus(1'b1, VEC3, 1'b1, 1'b0);
      waitCycle();
      bif.in_valid = 1'b0;
      waitCycle();
      rst_n = 1'b0;
      #1;
      checkResetOutputs("async_reset");
      #1;
      rst_n = 1'b1;
      runBlock(VEC3, got, lat);
      checkOutput("reset_after_data", got, RES3);

      // Randomized traffic with stalls and occasional aborts.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       {$urandom(), $urandom(), $urandom(), $urandom()},
                       ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 29) == 0));
         waitCycle();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      repeat (NCHUNK + 4) waitCycle();

      // Latency sweep across the other legal widths.
      for (int j = 0; j < 4; j++) begin
         sw_lat[j] = -1;
         sw_got[j] = '0;
      end
      sw_data  = VEC3;
      sw_valid = 1'b1;
      waitCycle();
      sw_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) begin
            if (sw_ov[j] && sw_lat[j] < 0) begin
               sw_lat[j] = k;
               sw_got[j] = sw_od[j];
            end
         end
      end
      for (int j = 0; j < 4; j++) begin
         checkOutput($sformatf("sweep_bpc%0d_latency", SW_BPC[j]), sw_lat[j], 16 / SW_BPC[j]);
         checkOutput($sformatf("sweep_bpc%0d_data", SW_BPC[j]), sw_got[j], RES3);
      end

      finishRun();
   end

endmodule
